s208_rate_monitor: RTL and testbench

- Downstream stage of the s208 fractional rate multiplier; consumes its Z output and the same P_0 enable that drives it.
- Measures how many Z pulses occur over a programmable window of P_0 enable cycles, so the C_8..C_0 rate setting can be checked in-system.
- Returns {z_count, overflow} to a controller through a valid/ready result handshake.

---
 rtl/s208_rate_monitor_pkg.sv | 17 +
 rtl/s208_rate_monitor_sample.sv | 42 ++++
 rtl/s208_rate_monitor.sv | 91 +++++++++
 tb/tb_s208_rate_monitor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/s208_rate_monitor_pkg.sv
// s208_rate_monitor_pkg: shared state encoding, default widths and saturating increment
// Contents: state_t (IDLE, ARM, COUNT, HOLD), CNT_W_DEF, WIN_W_DEF, sat_inc()
package s208_rate_monitor_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int WIN_W_DEF = 16;

    typedef enum logic [1:0] {IDLE, ARM, COUNT, HOLD} state_t;

    // Increments v and sticks at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] m;
        m = (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
        return (v >= m) ? m : v + 32'd1;
    endfunction

endpackage

// File: rtl/s208_rate_monitor_sample.sv
// s208_rate_monitor_sample: registers P_0/Z and produces the qualified Z event
// Ports: blif_clk_net, blif_reset_net (async, active-low), P_0, Z, clr (flush edge history),
//        p_q (registered enable), evt (qualified event).
// Z_EDGE_EN defined: evt is a rising edge of z_q; undefined: evt is the z_q level.
module s208_rate_monitor_sample (
    input  logic blif_clk_net,
    input  logic blif_reset_net,
    input  logic P_0,
    input  logic Z,
    input  logic clr,
    output logic p_q,
    output logic evt
);

    logic z_q;

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            p_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            p_q <= P_0;
            z_q <= Z;
        end
    end

`ifdef Z_EDGE_EN
    logic z_qq;

    // History is cleared while arming so a Z level left over from the
    // previous window cannot suppress or fake the first edge.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) z_qq <= 1'b0;
        else                 z_qq <= clr ? 1'b0 : z_q;
    end

    assign evt = p_q & z_q & ~z_qq & ~clr;
`else
    assign evt = p_q & z_q & ~clr;
`endif

endmodule

// File: rtl/s208_rate_monitor.sv
// s208_rate_monitor: counts Z events over a window of P_0 enable cycles and returns the result
// Ports: blif_clk_net, blif_reset_net (async, active-low), P_0, Z, start, abort, win_len,
//        busy, cfg_err, result_valid/result_ready handshake, result_count, result_ovf.
// Z_EDGE_EN selects rising-edge counting in the sample stage instead of level counting.
module s208_rate_monitor
    import s208_rate_monitor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             P_0,
    input  logic             Z,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    output logic             busy,
    output logic             cfg_err,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] result_count,
    output logic             result_ovf
);

    localparam logic [WIN_W-1:0] ONE_W = 1;

    state_t           state_q, state_d;
    logic             p_q, evt, accept, last, flush;
    logic [WIN_W-1:0] win_len_q, win_cnt;
    logic [CNT_W-1:0] z_cnt;
    logic             ovf;

    s208_rate_monitor_sample u_sample (
        .blif_clk_net  (blif_clk_net),
        .blif_reset_net(blif_reset_net),
        .P_0           (P_0),
        .Z             (Z),
        .clr           (state_q == ARM),
        .p_q           (p_q),
        .evt           (evt)
    );

    // abort has priority over start in IDLE.
    assign accept = state_q == IDLE && start && !abort && win_len != '0;
    assign last   = state_q == COUNT && !abort && p_q && win_cnt == win_len_q - ONE_W;
    assign flush  = accept || ((state_q == ARM || state_q == COUNT) && abort);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ARM : IDLE;
            ARM:     state_d = abort ? IDLE : COUNT;
            COUNT:   state_d = abort ? IDLE : last ? HOLD : COUNT;
            HOLD:    state_d = result_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q   <= IDLE;
            cfg_err   <= 1'b0;
            win_len_q <= '0;
            win_cnt   <= '0;
            z_cnt     <= '0;
            ovf       <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_err <= state_q == IDLE && start && !abort && win_len == '0;
            if (accept) win_len_q <= win_len;
            if (flush) begin
                win_cnt <= '0;
                z_cnt   <= '0;
                ovf     <= 1'b0;
            end else if (state_q == COUNT && p_q) begin
                win_cnt <= win_cnt + ONE_W;
                if (evt) begin
                    z_cnt <= CNT_W'(sat_inc(32'(z_cnt), CNT_W));
                    ovf   <= ovf | (z_cnt == '1);
                end
            end
        end
    end

    assign busy         = state_q != IDLE;
    assign result_valid = state_q == HOLD;
    assign result_count = z_cnt;
    assign result_ovf   = ovf;

endmodule

// File: tb/tb_s208_rate_monitor.sv
// tb_s208_rate_monitor: scoreboard bench for a 16-bit and a 4-bit counter instance on shared stimulus
module tb_s208_rate_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        P_0 = 1'b0, Z = 1'b0, start = 1'b0, abort = 1'b0, rdy = 1'b1;
    logic [15:0] win_len = '0;
    logic        busy_a, cfg_a, v_a, ovf_a;
    logic [15:0] cnt_a;
    logic        busy_b, cfg_b, v_b, ovf_b;
    logic [3:0]  cnt_b;
    int          vectors = 0, miscompares = 0, lat;

    typedef struct {int cnt; bit ovf;} exp_t;
    exp_t q_a[$], q_b[$];
    exp_t ea, eb;

`ifdef Z_EDGE_EN
    localparam int EDGE_EXP = 1;
`else
    localparam int EDGE_EXP = 8;
`endif

    s208_rate_monitor #(.CNT_W(16), .WIN_W(16)) dut_a (
        .blif_clk_net(clk), .blif_reset_net(rst_n), .P_0(P_0), .Z(Z),
        .start(start), .abort(abort), .win_len(win_len), .busy(busy_a),
        .cfg_err(cfg_a), .result_valid(v_a), .result_ready(rdy),
        .result_count(cnt_a), .result_ovf(ovf_a)
    );

    s208_rate_monitor #(.CNT_W(4), .WIN_W(16)) dut_b (
        .blif_clk_net(clk), .blif_reset_net(rst_n), .P_0(P_0), .Z(Z),
        .start(start), .abort(abort), .win_len(win_len), .busy(busy_b),
        .cfg_err(cfg_b), .result_valid(v_b), .result_ready(rdy),
        .result_count(cnt_b), .result_ovf(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && v_a && rdy) begin
            if (q_a.size() == 0) chk("unexpected result a", 1, 0);
            else begin
                ea = q_a.pop_front();
                chk("count a", cnt_a, ea.cnt);
                chk("ovf a", ovf_a, ea.ovf);
            end
        end
        if (rst_n && v_b && rdy) begin
            if (q_b.size() == 0) chk("unexpected result b", 1, 0);
            else begin
                eb = q_b.pop_front();
                chk("count b", cnt_b, eb.cnt);
                chk("ovf b", ovf_b, eb.ovf);
            end
        end
    end

    function automatic bit p_of(input int mode, input int i);
        return (mode == 2) ? (i % 2 == 1) : (mode <= 3);
    endfunction

    function automatic bit z_of(input int mode, input int i);
        case (mode)
            1:       return i % 4 == 0;
            3:       return i >= 1 && i <= 8;
            default: return 1'b1;
        endcase
    endfunction

    // mode 0: P=1,Z=1 (plus a start while busy); 1: Z every 4th; 2: P toggling; 3: Z burst of 8
    task automatic launch(input int wl, input int mode, input int exp_n, output int l);
        exp_t x;
        x.cnt = exp_n; x.ovf = 1'b0; q_a.push_back(x);
        x.cnt = exp_n > 15 ? 15 : exp_n; x.ovf = exp_n > 15; q_b.push_back(x);
        l = -1;
        for (int i = 0; i < 2 * wl + 20; i++) begin
            @(posedge clk); #1;
            start   = (i == 0) || (mode == 0 && i == 3);
            win_len = (i == 0) ? 16'(wl) : 16'd0;
            P_0     = p_of(mode, i);
            Z       = z_of(mode, i);
            @(negedge clk);
            if (mode == 0 && i == 4) chk("cfg_err while busy", cfg_a, 0);
            if (v_a) begin
                l = i;
                break;
            end
        end
        start = 1'b0; P_0 = 1'b0; Z = 1'b0;
        if (l < 0) chk("window timeout", 0, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy_a, 0);
        chk("reset valid", v_a, 0);
        chk("reset count", cnt_a, 0);
        chk("reset ovf", ovf_a, 0);
        chk("reset cfg_err", cfg_a, 0);
        @(negedge clk) rst_n = 1'b1;

        launch(8, 0, 8, lat);
        chk("latency level", lat, 10);

        @(posedge clk); #1 start = 1'b1; win_len = 16'd0;
        @(negedge clk) chk("zero win busy", busy_a, 0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("cfg_err pulse", cfg_a, 1);
        chk("zero win busy after", busy_a, 0);
        @(posedge clk); #1;
        @(negedge clk) chk("cfg_err single", cfg_a, 0);

        rdy = 1'b0;
        launch(100, 1, 25, lat);
        chk("latency rate", lat, 102);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold valid", v_a, 1);
            chk("hold count", cnt_a, 25);
        end
        @(posedge clk); #1 rdy = 1'b1;
        @(negedge clk) chk("valid at ready", v_a, 1);
        @(posedge clk); #1;
        @(negedge clk) chk("valid drop", v_a, 0);

        launch(4, 2, 4, lat);
        chk("latency gated", lat, 9);

        launch(20, 0, 20, lat);

        launch(8, 3, EDGE_EXP, lat);
        chk("latency burst", lat, 10);

        @(posedge clk); #1 start = 1'b1; win_len = 16'd8; P_0 = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) chk("busy stuck window", busy_a, 1);
        @(posedge clk); #1 abort = 1'b1; P_0 = 1'b1; Z = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort busy", busy_a, 0);
        chk("abort valid", v_a, 0);
        repeat (20) @(posedge clk);
        @(negedge clk) chk("no result after abort", v_a, 0);
        P_0 = 1'b0; Z = 1'b0;

        @(posedge clk); #1 start = 1'b1; abort = 1'b1; win_len = 16'd8;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk) chk("abort beats start", busy_a, 0);

        launch(8, 0, 8, lat);

        @(posedge clk); #1 start = 1'b1; win_len = 16'd50; P_0 = 1'b1; Z = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("busy before reset", busy_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset busy", busy_a, 0);
        chk("mid reset count a", cnt_a, 0);
        chk("mid reset count b", cnt_b, 0);
        chk("mid reset ovf", ovf_b, 0);
        chk("mid reset valid", v_a, 0);
        @(negedge clk) rst_n = 1'b1;
        P_0 = 1'b0; Z = 1'b0;
        @(posedge clk); #1;
        @(negedge clk) chk("post reset busy", busy_a, 0);

        launch(8, 0, 8, lat);

        for (int k = 0; k < 50 && (q_a.size() != 0 || q_b.size() != 0); k++) @(posedge clk);
        chk("queue drained a", q_a.size(), 0);
        chk("queue drained b", q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
